ahb_bus_arbiter: RTL and testbench
==================================

Name: ahb_bus_arbiter

Overview:
- Arbitrates the shared AHB address/data path among NUM_MASTERS bus masters (our ahb_top master plus DMA/test masters).
- Issues one-hot grant (HGRANT), the address-phase owner ID (HMASTER) and HMASTLOCK to the address/write-data muxes.
- Burst-aware: never re-arbitrates inside a fixed-length burst or a locked sequence; otherwise round-robin.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16).
- MID_W, 2, width of HMASTER; must satisfy 2**MID_W >= NUM_MASTERS.
- DEFAULT_MASTER, 0, master parked on the bus when nobody requests.

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESET  in  1  synchronous reset, active-high.
- HBUSREQ  in  NUM_MASTERS  per-master bus request.
- HLOCK  in  NUM_MASTERS  per-master locked-transfer request, qualified by HBUSREQ.
- HTRANS  in  2  muxed transfer type of current owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HBURST  in  3  muxed burst type of current owner.
- HREADY  in  1  slave ready; arbitration state advances only when 1.
- HGRANT  out  NUM_MASTERS  one-hot grant, registered.
- HMASTER  out  MID_W  ID of the master owning the current address phase, registered.
- HMASTLOCK  out  1  current address phase belongs to a locked sequence, registered.

Behaviour:
- Reset (HRESET=1 at a rising edge): HGRANT = one-hot(DEFAULT_MASTER), HMASTER = DEFAULT_MASTER, HMASTLOCK = 0, state IDLE, beat counter 0, rr_ptr = DEFAULT_MASTER. Reset mid-burst aborts it immediately; no pending grant is retained.
- No state, grant or counter update occurs on an edge where HREADY=0 (wait states freeze everything).
- Beat counter load: on HTRANS=NONSEQ with HREADY=1:
  - WRAP4/INCR4 (010/011) load 4; WRAP8/INCR8 (100/101) load 8; WRAP16/INCR16 (110/111) load 16.
  - SINGLE (000) loads 1. INCR (001) loads 0, meaning undefined length.
- Counter decrement: each accepted NONSEQ/SEQ beat with HREADY=1 decrements by 1 (the load counts as the first beat). BUSY and IDLE do not decrement.
- States:
  - IDLE: default master parked. Go to OWNED when any HBUSREQ is set at an arbitration point.
  - OWNED: owner holds the bus; re-arbitrates at arbitration points.
  - BURST: fixed-length burst in progress, counter > 1; no re-arbitration.
  - LOCKED: owner has HLOCK=1; no re-arbitration until the owner drops HLOCK and its sequence completes.
- Arbitration point (edge with HREADY=1), any of:
  - (a) state IDLE or OWNED and counter <= 1;
  - (b) last beat of a fixed burst is accepted (counter goes 1 -> 0);
  - (c) INCR burst and owner's HBUSREQ=0;
  - (d) owner issues HTRANS=IDLE and is not locked.
- Selection (round-robin): search from rr_ptr+1 modulo NUM_MASTERS; the first set HBUSREQ wins. rr_ptr updates to the winner.
  - If no request is set, grant DEFAULT_MASTER and go to IDLE.
  - If only the owner requests, it keeps the bus with no gap cycle.
- Grant timing:
  - HGRANT changes at the arbitration-point edge.
  - HMASTER takes the new ID at the next HREADY=1 edge, when the new owner's address phase begins. The data phase of the old owner therefore completes under the old HMASTER.
- HMASTLOCK = HLOCK[owner] registered alongside HMASTER.
  - LOCKED is entered when the granted master has HLOCK=1.
  - LOCKED is exited at an arbitration point after HLOCK[owner] falls; one further transfer completes locked before release.
- Simultaneous events: a new request arriving in the same cycle as an arbitration point is considered; a request dropped in that cycle is not. Requests from non-owners never preempt BURST or LOCKED.
- Out-of-range IDs (NUM_MASTERS < 2**MID_W) are never granted.

Optional Feature:
- Macro AHB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is removed.
- Undefined: round-robin as above. All other rules are identical in both cases.

Test Plan:
- Reset: HRESET=1 for 2 cycles with HBUSREQ=4'b1111 -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0. After release, the first grant goes to master 1 (rr_ptr=0).
- Fixed burst hold: M0 granted, NONSEQ INCR4 plus 3 SEQ; M2 requests from beat 2 -> HGRANT switches to 4'b0100 only on the edge accepting beat 4; HMASTER=2 one HREADY edge later.
- Wait-state freeze: same INCR4 with HREADY=0 for 3 cycles on beat 3 -> HGRANT and counter unchanged through the stall; handover still after beat 4.
- Round-robin fairness: HBUSREQ=4'b1111, all SINGLE transfers -> grant order 1,2,3,0,1 (with macro defined: 0,0,0,... while M0 requests).
- Lock: M3 with HLOCK=1 issues 3 SINGLE transfers while M1 requests -> HMASTLOCK=1, no grant change until M3 drops HLOCK and one more transfer completes, then HGRANT=4'b0010.
- Mid-burst reset: HRESET asserted at beat 3 of a WRAP8 -> next edge HGRANT=one-hot(DEFAULT_MASTER), state IDLE, counter 0.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ahb_bus_arbiter                                                           |
// | Burst/lock-aware round-robin AHB arbiter (fixed priority when             |
// | AHB_ARB_FIXED_PRIO_EN is defined).                                        |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MID_W          = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MID_W-1:0]       HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_OWNED  = 2'd1;
  localparam logic [1:0] c_ST_BURST  = 2'd2;
  localparam logic [1:0] c_ST_LOCKED = 2'd3;

  localparam logic [1:0]             c_HT_IDLE   = 2'b00;
  localparam logic [1:0]             c_HT_NONSEQ = 2'b10;
  localparam logic [2:0]             c_HB_INCR   = 3'b001;
  localparam logic [MID_W-1:0]       c_DEF_ID    = MID_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] c_DEF_GNT   = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [1:0]             r_state;
  logic [4:0]             r_cnt;
  logic                   r_incr;
  logic                   r_unlock;
  logic [MID_W-1:0]       r_gnt_id;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [MID_W-1:0]       r_hmaster;
  logic                   r_mastlock;
`ifndef AHB_ARB_FIXED_PRIO_EN
  logic [MID_W-1:0]       r_rr_ptr;
`endif

  logic             w_beat;
  logic             w_nonseq;
  logic             w_idle;
  logic [4:0]       w_load;
  logic [4:0]       w_cur;
  logic [4:0]       w_cnt_nxt;
  logic             w_last;
  logic             w_incr_cur;
  logic             w_own_req;
  logic             w_own_lock;
  logic             w_arb;
  logic             w_found;
  logic             w_win_lock;
  logic [MID_W-1:0] w_win;
  int               w_dist;
  int               w_best;

  assign w_beat   = HTRANS[1];
  assign w_nonseq = (HTRANS == c_HT_NONSEQ);
  assign w_idle   = (HTRANS == c_HT_IDLE);

  always_comb begin
    w_load = 5'd16;
    case (HBURST)
      3'b000:         w_load = 5'd1;
      3'b001:         w_load = 5'd0;
      3'b010, 3'b011: w_load = 5'd4;
      3'b100, 3'b101: w_load = 5'd8;
      default:        w_load = 5'd16;
    endcase
  end

  // A NONSEQ load already counts as the first beat, so it is decremented on the same edge.
  assign w_cur = w_nonseq ? w_load : r_cnt;

  always_comb begin
    w_cnt_nxt = w_cur;
    if (w_idle)
      w_cnt_nxt = 5'd0;
    else if (w_beat && (w_cur != 5'd0))
      w_cnt_nxt = w_cur - 5'd1;
  end

  assign w_last     = w_beat && (w_cur == 5'd1);
  assign w_incr_cur = w_nonseq ? (HBURST == c_HB_INCR) : (r_incr && !w_idle);
  assign w_own_req  = |(HBUSREQ & r_grant);
  assign w_own_lock = |(HBUSREQ & HLOCK & r_grant);

  always_comb begin
    w_arb = 1'b0;
    case (r_state)
      c_ST_BURST:  w_arb = w_last || w_idle;
      c_ST_LOCKED: w_arb = r_unlock &&
                           (!w_own_req || (w_beat && !w_incr_cur && (w_cnt_nxt == 5'd0)));
      default:     w_arb = w_idle || (w_incr_cur ? !w_own_req : (w_cnt_nxt <= 5'd1));
    endcase
  end

  always_comb begin
    w_found    = 1'b0;
    w_win      = c_DEF_ID;
    w_win_lock = 1'b0;
    w_best     = NUM_MASTERS;
    w_dist     = 0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
`ifdef AHB_ARB_FIXED_PRIO_EN
      w_dist = j;
`else
      // rr_ptr+1 scores 0 and rr_ptr itself scores last, so the owner keeps the bus only if alone
      w_dist = (j + 2 * NUM_MASTERS - 1 - int'(r_rr_ptr)) % NUM_MASTERS;
`endif
      if (HBUSREQ[j] && (w_dist < w_best)) begin
        w_found    = 1'b1;
        w_win      = MID_W'(j);
        w_win_lock = HLOCK[j];
        w_best     = w_dist;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state    <= c_ST_IDLE;
      r_cnt      <= 5'd0;
      r_incr     <= 1'b0;
      r_unlock   <= 1'b0;
      r_gnt_id   <= c_DEF_ID;
      r_grant    <= c_DEF_GNT;
      r_hmaster  <= c_DEF_ID;
      r_mastlock <= 1'b0;
`ifndef AHB_ARB_FIXED_PRIO_EN
      r_rr_ptr   <= c_DEF_ID;
`endif
    end else if (HREADY) begin
      // Address phase of the granted master starts now; lock flag follows its sequence.
      r_hmaster  <= r_gnt_id;
      r_mastlock <= (r_state == c_ST_LOCKED);
      r_cnt      <= w_cnt_nxt;
      r_incr     <= w_incr_cur;
      if (w_arb) begin
        r_unlock <= 1'b0;
        if (w_found) begin
          r_gnt_id <= w_win;
          r_grant  <= NUM_MASTERS'(1) << w_win;
`ifndef AHB_ARB_FIXED_PRIO_EN
          r_rr_ptr <= w_win;
`endif
          r_state  <= w_win_lock ? c_ST_LOCKED : c_ST_OWNED;
        end else begin
          r_gnt_id <= c_DEF_ID;
          r_grant  <= c_DEF_GNT;
          r_state  <= c_ST_IDLE;
        end
      end else if (r_state == c_ST_LOCKED) begin
        r_unlock <= r_unlock || !(|(HLOCK & r_grant));
      end else if (w_own_lock) begin
        r_state <= c_ST_LOCKED;
      end else if ((r_state != c_ST_BURST) && (w_cnt_nxt > 5'd1)) begin
        r_state <= c_ST_BURST;
      end
    end
  end

  assign HGRANT    = r_grant;
  assign HMASTER   = r_hmaster;
  assign HMASTLOCK = r_mastlock;

endmodule
`default_nettype wire

// File: tb/tb_ahb_bus_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_ahb_bus_arbiter                                                        |
// | Directed scenarios plus randomized single-transfer traffic vs. a model.   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_ahb_bus_arbiter;
  localparam int N   = 4;
  localparam int MW  = 2;
  localparam int DEF = 0;
`ifdef AHB_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  localparam logic [1:0] T_IDLE = 2'b00, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [N-1:0]  HBUSREQ;
  logic [N-1:0]  HLOCK;
  logic [1:0]    HTRANS;
  logic [2:0]    HBURST;
  logic          HREADY;
  logic [N-1:0]  HGRANT;
  logic [MW-1:0] HMASTER;
  logic          HMASTLOCK;

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  ahb_bus_arbiter #(.NUM_MASTERS(N), .MID_W(MW), .DEFAULT_MASTER(DEF)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY),
    .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  // Reference selection: walk the masters after the last winner (or from 0 in fixed mode).
  function automatic int pick(input logic [N-1:0] req, input int ptr);
    int w;
    int idx;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      idx = FIXED ? (k - 1) : ((ptr + k) % N);
      if (w < 0 && req[idx]) w = idx;
    end
    return w;
  endfunction

  task automatic drive(input logic rst, input logic [N-1:0] req, input logic [N-1:0] lck,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    HRESET = rst; HBUSREQ = req; HLOCK = lck; HTRANS = tr; HBURST = bu; HREADY = rdy;
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int gnt, input int hm, input logic ml);
    logic [N-1:0] g;
    g = N'(1) << gnt;
    chk({tag, ".HGRANT"}, 32'(HGRANT), 32'(g));
    chk({tag, ".HMASTER"}, 32'(HMASTER), 32'(hm));
    chk({tag, ".HMASTLOCK"}, 32'(HMASTLOCK), 32'(ml));
  endtask

  int           rr_g[5];
  int           rr_h[5];
  int           m_gnt, m_ptr, m_hm, pw;
  logic         s_rst, s_rdy;
  logic [N-1:0] s_req;
  logic [1:0]   s_tr;

  initial begin
    // Reset with everyone requesting: default master parked, first grant to M1 (M0 in fixed mode)
    drive(1'b1, 4'b1111, 4'b0000, T_IDLE, 3'b000, 1'b1);
    drive(1'b1, 4'b1111, 4'b0000, T_IDLE, 3'b000, 1'b1);
    chk_out("reset", 0, 0, 1'b0);
    if (FIXED) begin
      rr_g = '{0, 0, 0, 0, 0}; rr_h = '{0, 0, 0, 0, 0};
    end else begin
      rr_g = '{1, 2, 3, 0, 1}; rr_h = '{0, 1, 2, 3, 0};
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'b1111, 4'b0000, (k == 0) ? T_IDLE : T_NSEQ, 3'b000, 1'b1);
      chk_out($sformatf("rr%0d", k), rr_g[k], rr_h[k], 1'b0);
    end

    // Fixed INCR4 burst: M2 requests from beat 2, handover only on beat 4
    drive(1'b1, 4'b0000, 4'b0000, T_IDLE, 3'b000, 1'b1);
    drive(1'b0, 4'b0001, 4'b0000, T_IDLE, 3'b000, 1'b1);
    chk_out("bh.own", 0, 0, 1'b0);
    drive(1'b0, 4'b0001, 4'b0000, T_NSEQ, 3'b011, 1'b1);
    chk_out("bh.b1", 0, 0, 1'b0);
    drive(1'b0, 4'b0101, 4'b0000, T_SEQ, 3'b011, 1'b1);
    chk_out("bh.b2", 0, 0, 1'b0);
    drive(1'b0, 4'b0101, 4'b0000, T_SEQ, 3'b011, 1'b1);
    chk_out("bh.b3", 0, 0, 1'b0);
    drive(1'b0, 4'b0100, 4'b0000, T_SEQ, 3'b011, 1'b1);
    chk_out("bh.b4", 2, 0, 1'b0);
    drive(1'b0, 4'b0100, 4'b0000, T_IDLE, 3'b000, 1'b1);
    chk_out("bh.hm", 2, 2, 1'b0);

    // Same burst with a 3-cycle wait state on beat 3
    drive(1'b1, 4'b0000, 4'b0000, T_IDLE, 3'b000, 1'b1);
    drive(1'b0, 4'b0001, 4'b0000, T_IDLE, 3'b000, 1'b1);
    drive(1'b0, 4'b0001, 4'b0000, T_NSEQ, 3'b011, 1'b1);
    drive(1'b0, 4'b0101, 4'b0000, T_SEQ, 3'b011, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'b0101, 4'b0000, T_SEQ, 3'b011, 1'b0);
      chk_out($sformatf("ws.stall%0d", k), 0, 0, 1'b0);
    end
    drive(1'b0, 4'b0101, 4'b0000, T_SEQ, 3'b011, 1'b1);
    chk_out("ws.b3", 0, 0, 1'b0);
    drive(1'b0, 4'b0100, 4'b0000, T_SEQ, 3'b011, 1'b1);
    chk_out("ws.b4", 2, 0, 1'b0);
    drive(1'b0, 4'b0100, 4'b0000, T_IDLE, 3'b000, 1'b1);
    chk_out("ws.hm", 2, 2, 1'b0);

    // Locked sequence by M3 while M1 waits
    drive(1'b1, 4'b0000, 4'b0000, T_IDLE, 3'b000, 1'b1);
    drive(1'b0, 4'b1000, 4'b1000, T_IDLE, 3'b000, 1'b1);
    chk_out("lk.grant", 3, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'b1010, 4'b1000, T_NSEQ, 3'b000, 1'b1);
      chk_out($sformatf("lk.single%0d", k), 3, 3, 1'b1);
    end
    drive(1'b0, 4'b1010, 4'b0000, T_IDLE, 3'b000, 1'b1);
    chk_out("lk.drop", 3, 3, 1'b1);
    drive(1'b0, 4'b1010, 4'b0000, T_NSEQ, 3'b000, 1'b1);
    chk_out("lk.release", 1, 3, 1'b1);
    drive(1'b0, 4'b0010, 4'b0000, T_IDLE, 3'b000, 1'b1);
    chk_out("lk.after", 1, 1, 1'b0);

    // Reset in the middle of a WRAP8 burst
    drive(1'b1, 4'b0000, 4'b0000, T_IDLE, 3'b000, 1'b1);
    drive(1'b0, 4'b0010, 4'b0000, T_IDLE, 3'b000, 1'b1);
    drive(1'b0, 4'b0010, 4'b0000, T_NSEQ, 3'b100, 1'b1);
    chk_out("mr.b1", 1, 1, 1'b0);
    drive(1'b0, 4'b0010, 4'b0000, T_SEQ, 3'b100, 1'b1);
    drive(1'b1, 4'b0010, 4'b0000, T_SEQ, 3'b100, 1'b1);
    chk_out("mr.reset", 0, 0, 1'b0);
    drive(1'b0, 4'b1111, 4'b0000, T_SEQ, 3'b100, 1'b1);
    chk_out("mr.rearb", FIXED ? 0 : 1, 0, 1'b0);

    // Randomized single transfers, requests, wait states and resets against the model
    drive(1'b1, 4'b0000, 4'b0000, T_IDLE, 3'b000, 1'b1);
    m_gnt = DEF; m_ptr = DEF; m_hm = DEF;
    for (int c = 0; c < 300; c++) begin
      s_rst = ($urandom_range(0, 99) < 3);
      s_rdy = ($urandom_range(0, 3) != 0);
      s_req = N'($urandom_range(0, (1 << N) - 1));
      s_tr  = 2'($urandom_range(0, 3));
      if (s_rst) begin
        m_gnt = DEF; m_ptr = DEF; m_hm = DEF;
      end else if (s_rdy) begin
        m_hm = m_gnt;
        pw   = pick(s_req, m_ptr);
        if (pw >= 0) begin
          m_gnt = pw;
          if (!FIXED) m_ptr = pw;
        end else begin
          m_gnt = DEF;
        end
      end
      drive(s_rst, s_req, 4'b0000, s_tr, 3'b000, s_rdy);
      chk_out($sformatf("rand%0d", c), m_gnt, m_hm, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
